// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch unit and the controller.
// Covers fetch FSM states, the reset NOP, and instruction field positions.
package riscv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB   = 0;
  localparam int OP_MSB   = 6;
  localparam int F3_LSB   = 12;
  localparam int F3_MSB   = 14;
  localparam int F7_5_BIT = 30;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches over a valid/ready bus,
// and holds each instruction until execute retires it.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [6:0]  op_o,
  output logic [2:0]  funct3_o,
  output logic        funct7_5_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  input  logic        pc_src_i,
  input  logic [31:0] pc_target_i,
  output logic        fault_o,
  output logic [31:0] retire_count_o
);

  fetch_state_t state, state_nx;
  logic [31:0]  pc, pc_nx;
  logic [31:0]  instr, instr_nx;
  logic [31:0]  cnt, cnt_nx;
  logic [31:0]  pc_inc;
  logic         misalign;

  assign pc_inc   = pc + 32'd4;
  assign misalign = pc_src_i & (|pc_target_i[1:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      instr <= instr_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = instr;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        if (imem_req_ready_i) state_nx = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid_i) begin
          if (imem_rsp_err_i) begin
            state_nx = FAULT;
          end else begin
            instr_nx = imem_rsp_data_i;
            state_nx = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready_i) begin
          cnt_nx = cnt + 32'd1;
          // A misaligned redirect keeps the PC of the offending instruction
          if (misalign) begin
            state_nx = FAULT;
          end else begin
            pc_nx    = pc_src_i ? pc_target_i : pc_inc;
            state_nx = REQ;
          end
        end
      end
      FAULT: state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

  assign imem_req_valid_o = (state == REQ);
  assign imem_req_addr_o  = pc;
  assign instr_valid_o    = (state == HOLD);
  assign fault_o          = (state == FAULT);
  assign instr_o          = instr;
  assign op_o             = instr[OP_MSB:OP_LSB];
  assign funct3_o         = instr[F3_MSB:F3_LSB];
  assign funct7_5_o       = instr[F7_5_BIT];
  assign pc_o             = pc;
  assign pc_plus4_o       = pc_inc;
  assign retire_count_o   = cnt;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: expected fetch addresses are
// queued on reset/retire and compared at each request handshake.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        fault;
  logic [31:0] retire_count;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .imem_rsp_err_i   (rsp_err),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_o          (instr),
    .op_o             (op),
    .funct3_o         (funct3),
    .funct7_5_o       (funct7_5),
    .pc_o             (pc),
    .pc_plus4_o       (pc_plus4),
    .pc_src_i         (pc_src),
    .pc_target_i      (pc_target),
    .fault_o          (fault),
    .retire_count_o   (retire_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pc_m;
  logic [31:0] cnt_m;
  logic [31:0] held_m;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_addr(output logic [31:0] a);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
      a = 32'hDEAD_BEEF;
    end else begin
      a = exp_q.pop_front();
    end
  endtask

  // Called with the DUT in REQ; ends one cycle after the response.
  task automatic fetch(input logic [31:0] data, input int stall,
                       input bit err, input bit stray);
    logic [31:0] a;
    logic [31:0] front;
    front = (exp_q.size() != 0) ? exp_q[0] : 32'hDEAD_BEEF;
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", {31'd0, req_valid}, 32'd1);
      check("stall_addr", req_addr, front);
      req_ready = 0;
      rsp_valid = stray;
      rsp_data  = 32'hBAD0_BAD3;
      step();
      rsp_valid = 0;
    end
    pop_addr(a);
    check("req_valid", {31'd0, req_valid}, 32'd1);
    check("req_addr", req_addr, a);
    req_ready = 1;
    step();
    req_ready = 0;
    check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
    rsp_valid = 1;
    rsp_data  = data;
    rsp_err   = err;
    step();
    rsp_valid = 0;
    rsp_err   = 0;
    pc_m = a;
    if (err) begin
      check("err_fault", {31'd0, fault}, 32'd1);
      check("err_pc", pc, a);
      check("err_no_req", {31'd0, req_valid}, 32'd0);
    end else begin
      held_m = data;
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("instr", instr, data);
      check("op", {25'd0, op}, {25'd0, data[6:0]});
      check("funct3", {29'd0, funct3}, {29'd0, data[14:12]});
      check("funct7_5", {31'd0, funct7_5}, {31'd0, data[30]});
      check("pc", pc, a);
      check("pc_plus4", pc_plus4, a + 32'd4);
    end
  endtask

  task automatic retire(input bit src, input logic [31:0] tgt);
    bit bad;
    bad = src && (tgt[1:0] != 2'b00);
    cnt_m = cnt_m + 32'd1;
    if (!bad) exp_q.push_back(src ? tgt : pc_m + 32'd4);
    instr_ready = 1;
    pc_src      = src;
    pc_target   = tgt;
    step();
    instr_ready = 0;
    pc_src      = 0;
    pc_target   = 32'hFFFF_FFFF;
    check("retire_count", retire_count, cnt_m);
    if (bad) begin
      check("mis_fault", {31'd0, fault}, 32'd1);
      check("mis_pc", pc, pc_m);
      check("mis_no_req", {31'd0, req_valid}, 32'd0);
    end else begin
      check("next_req", {31'd0, req_valid}, 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_req", {31'd0, req_valid}, 32'd0);
    check("rst_ivalid", {31'd0, instr_valid}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_count", retire_count, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc4", pc_plus4, RST_PC + 32'd4);
    step();
    rst = 0;
    exp_q.delete();
    exp_q.push_back(RST_PC);
    cnt_m = 0;
    check("idle_no_req", {31'd0, req_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    rst = 1; req_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_err = 0;
    instr_ready = 0; pc_src = 0; pc_target = 0;
    cnt_m = 0; pc_m = 0; held_m = 0;
    step();
    // instr_ready with nothing held must not count
    instr_ready = 1;
    do_reset();
    instr_ready = 0;
    step();

    fetch(32'h0000_0013, 0, 0, 0);
    check("first_op", {25'd0, op}, 32'h13);
    check("first_pc4", pc_plus4, 32'd4);
    retire(0, 32'h0);
    fetch(32'h4000_5033, 2, 0, 0);
    retire(0, 32'h0);
    fetch(32'h0020_8093, 2, 0, 0);
    retire(0, 32'h0);
    check("count3", retire_count, 32'd3);

    fetch(32'h0000_006F, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      rsp_valid = 1;
      rsp_data  = 32'h1234_5678;
      step();
      rsp_valid = 0;
      check("hold_stable", instr, held_m);
      check("hold_valid2", {31'd0, instr_valid}, 32'd1);
    end
    retire(1, 32'h0000_0100);
    fetch(32'hC000_7013, 0, 0, 0);
    retire(1, 32'hFFFF_FFFC);
    fetch(32'h0000_0013, 1, 0, 0);
    retire(0, 32'h0);
    fetch(32'h0000_0013, 0, 0, 0);
    retire(1, 32'h0000_0008);
    fetch(32'h0000_0013, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      req_ready = 1;
      rsp_valid = 1;
      instr_ready = 1;
      step();
      check("fault_stuck", {31'd0, fault}, 32'd1);
      check("fault_no_req", {31'd0, req_valid}, 32'd0);
      check("fault_pc", pc, 32'd8);
    end
    req_ready = 0; rsp_valid = 0; instr_ready = 0;

    do_reset();
    step();
    fetch(32'h0000_0013, 0, 0, 0);
    retire(1, 32'h0000_0102);
    step();
    check("mis_stuck", {31'd0, req_valid}, 32'd0);
    check("mis_count", retire_count, 32'd1);

    do_reset();
    step();
    pop_addr(a);
    check("pre_wait_addr", req_addr, a);
    req_ready = 1;
    step();
    req_ready = 0;
    do_reset();
    rsp_valid = 1;
    rsp_data  = 32'hFFFF_FFFF;
    step();
    check("stale_req", {31'd0, req_valid}, 32'd1);
    check("stale_ivalid", {31'd0, instr_valid}, 32'd0);
    check("stale_instr", instr, 32'h0000_0013);
    rsp_valid = 0;
    fetch(32'h0000_0033, 0, 0, 0);
    check("post_rst_count", retire_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
